diff_io_ctrl: RTL and testbench

- Parametrised successor to the static differential driver for the extension-connector LVDS-style pairs.
- Each of INOUT_WIDTH pairs is independently configured at run time as off (hi-Z), static drive, pulse-stretched drive, or differential input.
- Input pairs pass through a synchroniser and edge detector.
- Sits between the lockbox logic/register bank and the top-level p/n inout pads.

---
 rtl/diff_io_pkg.sv | 11 +
 rtl/diff_io_chan.sv | 158 +++++++++++++++
 rtl/diff_io_ctrl.sv | 54 +++++
 tb/tb_diff_io_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/diff_io_pkg.sv
// diff_io_pkg: pair mode encoding shared by the differential pad controller.
package diff_io_pkg;

    typedef logic [1:0] mode_t;

    localparam logic [1:0] MODE_OFF    = 2'd0;
    localparam logic [1:0] MODE_STATIC = 2'd1;
    localparam logic [1:0] MODE_PULSE  = 2'd2;
    localparam logic [1:0] MODE_INPUT  = 2'd3;

endpackage

// File: rtl/diff_io_chan.sv
// diff_io_chan: one differential pair -- mode/data registers, pulse stretcher,
// input synchroniser with edge detect and p==n detection, pad drive enables.
// Build option: DIFF_IO_FILTER_EN adds a FILTER_LEN-cycle glitch filter
// in front of din_q.
module diff_io_chan
    import diff_io_pkg::*;
#(
    parameter int PULSE_W     = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [1:0]         mode,
    input  logic [PULSE_W-1:0] pulse_len,
    input  logic               din,
    input  logic               pad_p,
    input  logic               pad_n,
    output logic               drv_en,
    output logic               drv_val,
    output logic               din_q,
    output logic               rise,
    output logic               fall,
    output logic               busy,
    output logic               inv_err
);

`ifdef DIFF_IO_FILTER_EN
    localparam int LAT = SYNC_STAGES + FILTER_LEN + 1;
`else
    localparam int LAT = SYNC_STAGES + 1;
`endif
    // edges are only trusted once both din_q and its previous value are real
    localparam int WARM_MAX = LAT + 1;
    localparam int WW       = $clog2(WARM_MAX + 1);

    mode_t                  mode_r;
    logic                   din_r, din_d, armed;
    logic [PULSE_W-1:0]     cnt;
    logic [SYNC_STAGES-1:0] sync_p, sync_eq;
    logic [WW-1:0]          warm;
    logic                   q, q_prev, err;
    logic                   is_pulse, is_in, trig, p_s, eq_s, warm_done;
    logic                   q_src, q_upd;

    assign is_pulse  = (mode_r == MODE_PULSE);
    assign is_in     = (mode_r == MODE_INPUT);
    // armed keeps a din edge coinciding with pulse-mode entry from firing
    assign trig      = armed & din_r & ~din_d;
    assign p_s       = sync_p[SYNC_STAGES-1];
    assign eq_s      = sync_eq[SYNC_STAGES-1];
    assign warm_done = (warm == WW'(WARM_MAX));

    // mode and data capture; pads follow these one cycle after the inputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mode_r <= MODE_OFF;
            din_r  <= 1'b0;
            din_d  <= 1'b0;
            armed  <= 1'b0;
        end else begin
            mode_r <= mode;
            din_r  <= din;
            din_d  <= din_r;
            armed  <= is_pulse;
        end
    end

    // pulse stretcher: (re)load on din rise, count down to zero
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            cnt <= '0;
        else if (!is_pulse)
            cnt <= '0;
        else if (trig)
            cnt <= (pulse_len == '0) ? PULSE_W'(1) : pulse_len;
        else if (cnt != '0)
            cnt <= cnt - PULSE_W'(1);
    end

    // synchronisers for level and p==n, held clear outside input mode
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_p  <= '0;
            sync_eq <= '0;
            warm    <= '0;
        end else if (!is_in) begin
            sync_p  <= '0;
            sync_eq <= '0;
            warm    <= '0;
        end else begin
            sync_p  <= {sync_p[SYNC_STAGES-2:0], pad_p};
            sync_eq <= {sync_eq[SYNC_STAGES-2:0], pad_p ~^ pad_n};
            if (!warm_done)
                warm <= warm + WW'(1);
        end
    end

`ifdef DIFF_IO_FILTER_EN
    localparam int FW = $clog2(FILTER_LEN + 1);
    logic          filt;
    logic [FW-1:0] fcnt;

    // glitch filter: accept a new level after FILTER_LEN differing cycles
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            filt <= 1'b0;
            fcnt <= '0;
        end else if (!is_in) begin
            filt <= 1'b0;
            fcnt <= '0;
        end else if (eq_s) begin
            fcnt <= fcnt;
        end else if (p_s == filt) begin
            fcnt <= '0;
        end else if (fcnt == FW'(FILTER_LEN - 1)) begin
            filt <= p_s;
            fcnt <= '0;
        end else begin
            fcnt <= fcnt + FW'(1);
        end
    end

    assign q_src = filt;
    assign q_upd = 1'b1;
`else
    assign q_src = p_s;
    assign q_upd = ~eq_s;
`endif

    // input level, its history for edges, sticky invalid-pair flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q      <= 1'b0;
            q_prev <= 1'b0;
            err    <= 1'b0;
        end else if (!is_in) begin
            q      <= 1'b0;
            q_prev <= 1'b0;
            err    <= 1'b0;
        end else begin
            q_prev <= q;
            if (q_upd)
                q <= q_src;
            if (eq_s)
                err <= 1'b1;
        end
    end

    assign din_q   = q;
    assign rise    = warm_done & q & ~q_prev;
    assign fall    = warm_done & ~q & q_prev;
    assign inv_err = err;
    assign busy    = (cnt != '0);
    assign drv_en  = (mode_r == MODE_STATIC) | is_pulse;
    assign drv_val = is_pulse ? busy : din_r;

endmodule

// File: rtl/diff_io_ctrl.sv
// diff_io_ctrl: INOUT_WIDTH independent differential pairs with tri-state
// p/n pads. Build option: DIFF_IO_FILTER_EN enables the input glitch filter.
module diff_io_ctrl
    import diff_io_pkg::*;
#(
    parameter int INOUT_WIDTH = 8,
    parameter int PULSE_W     = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [2*INOUT_WIDTH-1:0] mode,
    input  logic [PULSE_W-1:0]       pulse_len,
    input  logic [INOUT_WIDTH-1:0]   din,
    inout  wire  [INOUT_WIDTH-1:0]   dout_p,
    inout  wire  [INOUT_WIDTH-1:0]   dout_n,
    output logic [INOUT_WIDTH-1:0]   din_q,
    output logic [INOUT_WIDTH-1:0]   rise,
    output logic [INOUT_WIDTH-1:0]   fall,
    output logic [INOUT_WIDTH-1:0]   busy,
    output logic [INOUT_WIDTH-1:0]   inv_err
);

    logic [INOUT_WIDTH-1:0] drv_en, drv_val;

    for (genvar gi = 0; gi < INOUT_WIDTH; gi++) begin : g_chan
        diff_io_chan #(
            .PULSE_W     (PULSE_W),
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_LEN  (FILTER_LEN)
        ) u_chan (
            .clk       (clk),
            .rstn      (rstn),
            .mode      (mode[2*gi +: 2]),
            .pulse_len (pulse_len),
            .din       (din[gi]),
            .pad_p     (dout_p[gi]),
            .pad_n     (dout_n[gi]),
            .drv_en    (drv_en[gi]),
            .drv_val   (drv_val[gi]),
            .din_q     (din_q[gi]),
            .rise      (rise[gi]),
            .fall      (fall[gi]),
            .busy      (busy[gi]),
            .inv_err   (inv_err[gi])
        );

        // complementary drive when enabled, otherwise release both pads
        assign dout_p[gi] = drv_en[gi] ? drv_val[gi]  : 1'bz;
        assign dout_n[gi] = drv_en[gi] ? ~drv_val[gi] : 1'bz;
    end

endmodule

// File: tb/tb_diff_io_ctrl.sv
// tb_diff_io_ctrl: directed checks of static, pulse, input and reset behaviour.
module tb_diff_io_ctrl;
    import diff_io_pkg::*;

`ifdef DIFF_IO_FILTER_EN
    localparam int IN_LAT = 2 + 4 + 1;
`else
    localparam int IN_LAT = 2 + 1;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] mode;
    logic [15:0] pulse_len;
    logic [7:0]  din;
    wire  [7:0]  pad_p, pad_n;
    logic [7:0]  tb_oe, tb_p, tb_n;
    logic [7:0]  din_q, rise, fall, busy, inv_err;
    int          checks = 0;
    int          errors = 0;
    int          hi, bz, first, nr, nf;

    always #5 clk = ~clk;

    // bench-side pad drivers, used only while a pair is in input mode
    for (genvar g = 0; g < 8; g++) begin : g_pad
        assign pad_p[g] = tb_oe[g] ? tb_p[g] : 1'bz;
        assign pad_n[g] = tb_oe[g] ? tb_n[g] : 1'bz;
    end

    diff_io_ctrl dut (
        .clk       (clk),
        .rstn      (rstn),
        .mode      (mode),
        .pulse_len (pulse_len),
        .din       (din),
        .dout_p    (pad_p),
        .dout_n    (pad_n),
        .din_q     (din_q),
        .rise      (rise),
        .fall      (fall),
        .busy      (busy),
        .inv_err   (inv_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_mode(input int ch, input mode_t m);
        mode[2*ch +: 2] = m;
    endtask

    // drive din[1] from pat[c] before edge c, record ch1 pulse shape
    task automatic pulse_run(input logic [15:0] pat, output int h, output int b, output int f);
        h = 0; b = 0; f = 0;
        for (int c = 1; c <= 14; c++) begin
            din[1] = pat[c];
            tick;
            if (pad_p[1] === 1'b1 && pad_n[1] === 1'b0) begin
                h++;
                if (f == 0) f = c;
            end
            if (busy[1] === 1'b1) b++;
        end
    endtask

    task automatic in_watch(input int ch, input int n, output int f, output int r, output int fl);
        f = 0; r = 0; fl = 0;
        for (int c = 1; c <= n; c++) begin
            tick;
            if (din_q[ch] === 1'b1 && f == 0) f = c;
            if (rise[ch] === 1'b1) r++;
            if (fall[ch] === 1'b1) fl++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        // reset with random inputs
        rstn = 1'b0; mode = 16'($urandom); din = 8'($urandom);
        pulse_len = 16'($urandom); tb_oe = '0; tb_p = '0; tb_n = '0;
        repeat (3) tick;
        chk("rst_p_z", 32'(pad_p === 8'hzz), 1);
        chk("rst_n_z", 32'(pad_n === 8'hzz), 1);
        chk("rst_din_q", 32'(din_q), 0);
        chk("rst_rise", 32'(rise), 0);
        chk("rst_fall", 32'(fall), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_inv_err", 32'(inv_err), 0);
        mode = '0; din = '0; pulse_len = 16'd5; rstn = 1'b1;
        tick;

        // static on ch0, one cycle din->pad
        set_mode(0, MODE_STATIC);
        tick;
        chk("st_p_0a", 32'(pad_p[0]), 0);
        chk("st_n_0a", 32'(pad_n[0]), 1);
        din[0] = 1'b1;
        chk("st_latency", 32'(pad_p[0]), 0);
        tick;
        chk("st_p_1", 32'(pad_p[0]), 1);
        chk("st_n_1", 32'(pad_n[0]), 0);
        din[0] = 1'b0;
        tick;
        chk("st_p_0b", 32'(pad_p[0]), 0);
        chk("st_n_0b", 32'(pad_n[0]), 1);
        chk("off_z", 32'(pad_p[7:1] === 7'bzzzzzzz), 1);

        // pulse on ch1: single, retriggered, zero length
        set_mode(1, MODE_PULSE); din[1] = 1'b0;
        tick; tick;
        pulse_run(16'hFFFE, hi, bz, first);
        chk("pls_high", 32'(hi), 5);
        chk("pls_busy", 32'(bz), 5);
        chk("pls_start", 32'(first), 2);
        chk("pls_idle", 32'({pad_p[1], pad_n[1]}), 1);
        din[1] = 1'b0; tick; tick;
        pulse_run(16'hFFF2, hi, bz, first);
        chk("retrig_high", 32'(hi), 8);
        chk("retrig_start", 32'(first), 2);
        pulse_len = 16'd0; din[1] = 1'b0; tick; tick;
        pulse_run(16'hFFFE, hi, bz, first);
        chk("len0_high", 32'(hi), 1);
        chk("len0_busy", 32'(bz), 1);
        pulse_len = 16'd5;

        // input on ch2: level, edge, p==n hold/sticky, clear on leaving
        tb_oe[2] = 1'b1; tb_p[2] = 1'b0; tb_n[2] = 1'b1;
        set_mode(2, MODE_INPUT);
        repeat (12) tick;
        chk("in_q_init", 32'(din_q[2]), 0);
        chk("in_err_init", 32'(inv_err[2]), 0);
        tb_p[2] = 1'b1; tb_n[2] = 1'b0;
        in_watch(2, 10, first, nr, nf);
        chk("in_latency", 32'(first), IN_LAT);
        chk("in_rise_cnt", 32'(nr), 1);
        chk("in_fall_cnt", 32'(nf), 0);
        tb_n[2] = 1'b1;
        repeat (5) tick;
        chk("in_err_set", 32'(inv_err[2]), 1);
        chk("in_hold_11", 32'(din_q[2]), 1);
        tb_p[2] = 1'b0; tb_n[2] = 1'b0;
        repeat (12) tick;
        chk("in_hold_00", 32'(din_q[2]), 1);
        tb_p[2] = 1'b1; tb_n[2] = 1'b0;
        repeat (5) tick;
        chk("in_err_sticky", 32'(inv_err[2]), 1);
        set_mode(2, MODE_OFF); tb_oe[2] = 1'b0;
        tick; tick;
        chk("off_err_clr", 32'(inv_err[2]), 0);
        chk("off_q_clr", 32'(din_q[2]), 0);

        // entering input with the line already high gives no edge
        tb_oe[3] = 1'b1; tb_p[3] = 1'b1; tb_n[3] = 1'b0;
        set_mode(3, MODE_INPUT);
        in_watch(3, 12, first, nr, nf);
        chk("warm_rise", 32'(nr), 0);
        chk("warm_q", 32'(din_q[3]), 1);

`ifdef DIFF_IO_FILTER_EN
        // ch4 glitch filter: 3-cycle glitch rejected, held level accepted
        tb_oe[4] = 1'b1; tb_p[4] = 1'b0; tb_n[4] = 1'b1;
        set_mode(4, MODE_INPUT);
        repeat (12) tick;
        tb_p[4] = 1'b1; tb_n[4] = 1'b0;
        repeat (3) tick;
        tb_p[4] = 1'b0; tb_n[4] = 1'b1;
        in_watch(4, 10, first, nr, nf);
        chk("flt_glitch", 32'(first), 0);
        tb_p[4] = 1'b1; tb_n[4] = 1'b0;
        in_watch(4, 10, first, nr, nf);
        chk("flt_latency", 32'(first), 7);
        chk("flt_rise", 32'(nr), 1);
`endif

        // async reset mid-pulse on ch1
        din[1] = 1'b0; tick; tick;
        din[1] = 1'b1; tick; tick;
        chk("mid_pls_high", 32'(pad_p[1]), 1);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_p_z", 32'(pad_p[1] === 1'bz), 1);
        chk("mid_rst_n_z", 32'(pad_n[1] === 1'bz), 1);
        chk("mid_rst_busy", 32'(busy[1]), 0);
        tick; tick;
        rstn = 1'b1;
        hi = 0;
        for (int c = 0; c < 8; c++) begin
            tick;
            if (busy[1] === 1'b1 || pad_p[1] === 1'b1) hi++;
        end
        chk("post_rst_nopls", 32'(hi), 0);
        chk("post_rst_drv0", 32'({pad_p[1], pad_n[1]}), 1);
        din[1] = 1'b0; tick; tick;
        pulse_run(16'hFFFE, hi, bz, first);
        chk("post_rst_pls", 32'(hi), 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
